// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter moving bursts of bytes from N_REQ producers
// into a single UART transmitter byte input.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic                 grant_valid,
  output logic [2:0]           grant_id,
  output logic [CNT_W-1:0]     tx_count
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
  state_t            state_q;
  logic [IW-1:0]     gid_q, last_q, sel;
  logic              found, grant_valid_q;
  logic [3:0]        burst_q;
  logic [7:0]        tx_data_q;
  logic [CNT_W-1:0]  tx_count_q;
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] l, input int k);
    return IW'((int'(l) + k) % N_REQ);
  endfunction
  // Scan downward so the nearest requester after last_q is the one that sticks.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_valid[wrap_idx(last_q, k)]) begin
        found = 1'b1;
        sel   = wrap_idx(last_q, k);
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      gid_q         <= '0;
      last_q        <= IW'(N_REQ - 1);
      grant_valid_q <= 1'b0;
      burst_q       <= '0;
      tx_data_q     <= '0;
      tx_count_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (found) begin
          gid_q         <= sel;
          grant_valid_q <= 1'b1;
          burst_q       <= '0;
          state_q       <= LOAD;
        end
        LOAD: if (req_valid[gid_q]) begin
          tx_data_q <= req_data[{gid_q, 3'b000} +: 8];
          state_q   <= SEND;
        end else begin
          last_q        <= gid_q;
          grant_valid_q <= 1'b0;
          state_q       <= IDLE;
        end
        SEND: if (tx_ready) begin
          tx_count_q <= tx_count_q + CNT_W'(1);
          burst_q    <= burst_q + 4'd1;
          if (req_valid[gid_q] && burst_q < 4'(MAX_BURST - 1)) begin
            state_q <= LOAD;
          end else begin
            last_q        <= gid_q;
            grant_valid_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_ready   = (state_q == LOAD) ? N_REQ'(1) << gid_q : '0;
  assign tx_valid    = state_q == SEND;
  assign tx_data     = tx_data_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = 3'(gid_q);
  assign tx_count    = tx_count_q;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that lets N_REQ byte producers share one UART transmitter. Each producer offers bytes on a valid/ready handshake. The arbiter grants one producer at a time and moves that producer's bytes to the transmitter's byte input. A granted producer may send a burst of up to MAX_BURST consecutive bytes before the grant rotates. The block sits between the command/status sources and the uart_tx datapath, and runs in the system clock domain upstream of the baud generator.

Parameters:
N_REQ, 4, number of requesters (2..8)
MAX_BURST, 4, maximum bytes sent per grant before forced rotation (1..15)
CNT_W, 16, width of the transmitted-byte statistics counter

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  N_REQ  per-requester byte-available flag
req_data  input  8*N_REQ  per-requester byte; requester i uses bits [8*i+7:8*i]
req_ready  output  N_REQ  one-hot pulse; byte of requester i accepted this cycle
tx_valid  output  1  byte on tx_data is offered to the transmitter
tx_data  output  8  byte to transmit
tx_ready  input  1  transmitter can take a byte (holding register free)
grant_valid  output  1  a requester currently holds the grant
grant_id  output  3  index of the granted requester; valid only when grant_valid=1
tx_count  output  CNT_W  total bytes handed to the transmitter since reset; wraps at all-ones

Behaviour:
- Reset is asynchronous and active-high. While reset=1 and after release:
  - state=IDLE; req_ready=0, tx_valid=0, tx_data=0, grant_valid=0, grant_id=0, tx_count=0.
  - last_grant=N_REQ-1, so requester 0 has first priority.
  - burst_cnt=0.
- Reset asserted mid-operation aborts any byte in flight. The byte is neither retried nor counted.
- State machine: IDLE, LOAD, SEND.
- IDLE:
  - grant_valid=0, tx_valid=0.
  - If any req_valid bit is 1, select the first set bit scanning from last_grant+1 upward, wrapping modulo N_REQ.
  - Register the selection as grant_id, set grant_valid=1, burst_cnt=0, and go to LOAD on the next edge.
  - If no req_valid bit is set, stay in IDLE.
- LOAD:
  - req_ready[grant_id]=1; all other req_ready bits are 0. req_ready is a decode of state and grant_id.
  - If req_valid[grant_id]=1: tx_data <= the selected req_data byte, go to SEND.
  - If req_valid[grant_id]=0 (the requester withdrew): no transfer, last_grant <= grant_id, go to IDLE.
- SEND:
  - tx_valid=1, and tx_data is held stable until tx_ready=1.
  - On a cycle with tx_valid and tx_ready both high:
    - tx_count increments, wrapping.
    - burst_cnt increments.
    - If req_valid[grant_id]=1 and burst_cnt+1 < MAX_BURST, go to LOAD with the same grant.
    - Otherwise last_grant <= grant_id, grant_valid <= 0, and go to IDLE.
- Handshake rules:
  - A requester byte is consumed only when req_valid[i] and req_ready[i] are both 1.
  - A transmitter byte is consumed only when tx_valid and tx_ready are both 1.
  - tx_valid never drops before acceptance.
- Latency:
  - From req_valid rising in IDLE, req_ready is asserted 1 cycle later (LOAD), and tx_valid 2 cycles later.
  - Within a burst, consecutive accepted bytes are at least 2 cycles apart.
- Fairness: once every requester has valid held high, grants rotate strictly 0,1,…,N_REQ-1,0. No requester waits more than (N_REQ-1) bursts.
- Requests arriving while another requester is granted are not accepted until the arbiter returns to IDLE. Arbitration samples req_valid only in IDLE.
- grant_id is zero-extended to 3 bits. Bits at or above N_REQ are never selected.
- tx_ready held low leaves the block in SEND indefinitely with all outputs stable.

Test Plan:
- Reset: assert reset mid-SEND with tx_data=8'hA5 and tx_valid=1 → tx_valid=0, req_ready=0, grant_valid=0, tx_count=0 immediately (no clock edge needed).
- Single requester: req_valid=4'b0100, req_data byte2=8'h3C, tx_ready=1 → grant_id=2 after 1 cycle, req_ready=4'b0100 for 1 cycle, then tx_valid=1 with tx_data=8'h3C. tx_count goes 0→1.
- Burst limit: requester 1 keeps valid high with bytes 8'h01..8'h06, MAX_BURST=4 → exactly bytes 01,02,03,04 transmitted, then return to IDLE. Bytes 05,06 follow under a new grant after one IDLE cycle.
- Round-robin: all four req_valid held high, each requester sending one byte per burst (MAX_BURST=1) → grant_id sequence 0,1,2,3,0,1. tx_count=6 after six transfers.
- Backpressure: tx_ready=0 for 20 cycles while in SEND with tx_data=8'h7E → tx_valid stays 1, tx_data stays 8'h7E, no further req_ready pulse. tx_count increments once when tx_ready returns to 1.
- Withdraw and wrap: requester 3 drops valid in the LOAD cycle → no transfer, last_grant=3, so requester 0 is next. Separately, preload 65535 transfers → tx_count wraps to 0 on the next transfer.
